// File: rtl/serial_restore_adder_pkg.sv
// Shared definitions for the bit-serial restore adder: state encoding
// and the default operand width.
package serial_restore_adder_pkg;

    // Operand width used when the top is instantiated without override.
    localparam int DEFAULT_WIDTH = 8;

    // Controller states; encodings are fixed so waveforms stay readable.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder. The serial adder reuses this single cell once per
// cycle instead of building a W-bit ripple chain.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Plain sum and majority-carry equations.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_restore_adder.sv
// Bit-serial LSB-first adder that rebuilds the minuend a = d + b mod 2^W
// from the subtractor's difference and subtrahend, one bit per cycle.
// Optional feature macro: SERIAL_RESTORE_ADDER_CHECK_EN. When defined, the
// subtractor's borrow is captured and compared against the final carry to
// flag a mismatch; otherwise mismatch is tied low and no capture is built.
module serial_restore_adder
    import serial_restore_adder_pkg::*;
#(
    parameter int W = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] diff_in,
    input  logic [W-1:0] sub_in,
    input  logic         borrow_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum_out,
    output logic         carry_out,
    output logic         mismatch
);

    // Counter must hold W-1 without wrapping, including the W=1 case.
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    state_t state_q, state_d;

    logic [W-1:0]  diffShift_q;
    logic [W-1:0]  subShift_q;
    logic [W-1:0]  result_q;
    logic [CW-1:0] count_q;
    logic          carry_q;
    logic          carryOut_q;
    logic          done_q;

    logic          sumBit;
    logic          carryNext;
    logic [W-1:0]  diffShift_d;
    logic [W-1:0]  subShift_d;
    logic [W-1:0]  result_d;

    // The single adder cell always looks at the current operand LSBs.
    full_adder_bit uAdder (
        .a    (diffShift_q[0]),
        .b    (subShift_q[0]),
        .cin  (carry_q),
        .s    (sumBit),
        .cout (carryNext)
    );

    // Shifted versions of the operand and result registers; the sum bit
    // enters at the MSB so bit i ends up at position i after W shifts.
    always_comb begin
        diffShift_d = diffShift_q >> 1;
        subShift_d  = subShift_q >> 1;
        result_d    = result_q >> 1;
        result_d[W-1] = sumBit;
    end

    // State register; reset returns the controller to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (count_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs derived from state and the result registers.
    always_comb begin
        busy      = (state_q == SHIFT) || (state_q == DONE);
        done      = done_q;
        sum_out   = result_q;
        carry_out = carryOut_q;
    end

    // Serial datapath: capture on start, one add-and-shift per SHIFT cycle,
    // publish the final carry and raise done while leaving DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            diffShift_q <= '0;
            subShift_q  <= '0;
            result_q    <= '0;
            count_q     <= '0;
            carry_q     <= 1'b0;
            carryOut_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        diffShift_q <= diff_in;
                        subShift_q  <= sub_in;
                        result_q    <= '0;
                        count_q     <= '0;
                        carry_q     <= 1'b0;
                        carryOut_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    diffShift_q <= diffShift_d;
                    subShift_q  <= subShift_d;
                    result_q    <= result_d;
                    carry_q     <= carryNext;
                    count_q     <= count_q + CW'(1);
                end
                DONE: begin
                    carryOut_q <= carry_q;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_RESTORE_ADDER_CHECK_EN
    logic borrow_q;
    logic mismatch_q;

    // Borrow capture and carry comparison; cleared on every accepted start
    // so a stale flag never survives into the next operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            borrow_q   <= 1'b0;
            mismatch_q <= 1'b0;
        end else if ((state_q == IDLE) && start) begin
            borrow_q   <= borrow_in;
            mismatch_q <= 1'b0;
        end else if (state_q == DONE) begin
            mismatch_q <= carry_q ^ borrow_q;
        end
    end

    assign mismatch = mismatch_q;
`else
    logic unusedBorrow;

    assign unusedBorrow = borrow_in;
    assign mismatch     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_restore_adder.sv
// Directed bench for serial_restore_adder at W=4: reset values, latency,
// carry and check behaviour, ignored start, mid-operation reset and an
// exhaustive back-to-back sweep with start held high.
module tb_serial_restore_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] diffIn;
    logic [W-1:0] subIn;
    logic         borrowIn;
    logic         busy;
    logic         done;
    logic [W-1:0] sumOut;
    logic         carryOut;
    logic         mismatch;

    int checks;
    int errors;

    serial_restore_adder #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .diff_in   (diffIn),
        .sub_in    (subIn),
        .borrow_in (borrowIn),
        .busy      (busy),
        .done      (done),
        .sum_out   (sumOut),
        .carry_out (carryOut),
        .mismatch  (mismatch)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge and settle before sampling.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    int doneCount;
    logic [W-1:0] seenSum;
    logic [4:0] total;
    logic expMismatch;

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        diffIn   = '0;
        subIn    = '0;
        borrowIn = 1'b0;

        // Reset values.
        applyStimulus();
        applyStimulus();
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_sum", 32'(sumOut), 32'd0);
        checkOutput("reset_carry", 32'(carryOut), 32'd0);
        checkOutput("reset_mismatch", 32'(mismatch), 32'd0);
        rst = 1'b0;
        applyStimulus();

        // Basic add 3 + 5 with cycle-exact busy/done timing.
        $display("[TB] basic add");
        diffIn = 4'b0011; subIn = 4'b0101; borrowIn = 1'b0; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        checkOutput("basic_busy_c0", 32'(busy), 32'd1);
        checkOutput("basic_done_c0", 32'(done), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus();
            checkOutput($sformatf("basic_busy_c%0d", i), 32'(busy), 32'd1);
            checkOutput($sformatf("basic_done_c%0d", i), 32'(done), 32'd0);
        end
        applyStimulus();
        checkOutput("basic_done_c5", 32'(done), 32'd1);
        checkOutput("basic_busy_c5", 32'(busy), 32'd0);
        checkOutput("basic_sum", 32'(sumOut), 32'h8);
        checkOutput("basic_carry", 32'(carryOut), 32'd0);
        checkOutput("basic_mismatch", 32'(mismatch), 32'd0);
        applyStimulus();
        checkOutput("basic_done_c6", 32'(done), 32'd0);
        checkOutput("basic_sum_hold", 32'(sumOut), 32'h8);

        // Negative result: 13 + 5 = 18 -> 2 with carry, borrow matches.
        $display("[TB] negative result");
        diffIn = 4'b1101; subIn = 4'b0101; borrowIn = 1'b1; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int i = 1; i <= 5; i++) applyStimulus();
        checkOutput("neg_done", 32'(done), 32'd1);
        checkOutput("neg_sum", 32'(sumOut), 32'h2);
        checkOutput("neg_carry", 32'(carryOut), 32'd1);
        checkOutput("neg_mismatch", 32'(mismatch), 32'd0);
        applyStimulus();

        // Check path: same operands but borrow disagrees with the carry.
        $display("[TB] check path");
`ifdef SERIAL_RESTORE_ADDER_CHECK_EN
        expMismatch = 1'b1;
`else
        expMismatch = 1'b0;
`endif
        diffIn = 4'b1101; subIn = 4'b0101; borrowIn = 1'b0; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int i = 1; i <= 5; i++) applyStimulus();
        checkOutput("chk_done", 32'(done), 32'd1);
        checkOutput("chk_sum", 32'(sumOut), 32'h2);
        checkOutput("chk_carry", 32'(carryOut), 32'd1);
        checkOutput("chk_mismatch", 32'(mismatch), 32'(expMismatch));
        applyStimulus();

        // Start while busy is ignored; exactly one done with first result.
        $display("[TB] start while busy");
        diffIn = 4'b0011; subIn = 4'b0101; borrowIn = 1'b0; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        applyStimulus();
        diffIn = 4'hF; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        doneCount = 0;
        seenSum   = '0;
        for (int i = 3; i <= 8; i++) begin
            applyStimulus();
            if (done) begin
                doneCount++;
                seenSum = sumOut;
            end
        end
        checkOutput("busy_start_done_count", 32'(doneCount), 32'd1);
        checkOutput("busy_start_sum", 32'(seenSum), 32'h8);
        checkOutput("busy_start_idle", 32'(busy), 32'd0);

        // Reset during SHIFT aborts and suppresses done.
        $display("[TB] reset mid-operation");
        diffIn = 4'h7; subIn = 4'h0; borrowIn = 1'b0; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_sum", 32'(sumOut), 32'd0);
        checkOutput("rst_carry", 32'(carryOut), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        doneCount = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            if (done) doneCount++;
        end
        checkOutput("rst_no_done", 32'(doneCount), 32'd0);
        diffIn = 4'h1; subIn = 4'h1; start = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int i = 1; i <= 5; i++) applyStimulus();
        checkOutput("rst_after_done", 32'(done), 32'd1);
        checkOutput("rst_after_sum", 32'(sumOut), 32'h2);
        checkOutput("rst_after_carry", 32'(carryOut), 32'd0);

        // Exhaustive sweep with start held high: one result every 6 cycles.
        $display("[TB] exhaustive back-to-back");
        start = 1'b1;
        for (int d = 0; d < 16; d++) begin
            for (int b = 0; b < 16; b++) begin
                total    = 5'(d) + 5'(b);
                diffIn   = 4'(d);
                subIn    = 4'(b);
                borrowIn = total[4];
                applyStimulus();
                for (int i = 1; i <= 4; i++) applyStimulus();
                checkOutput($sformatf("sweep_predone_%0d_%0d", d, b), 32'(done), 32'd0);
                applyStimulus();
                checkOutput($sformatf("sweep_done_%0d_%0d", d, b), 32'(done), 32'd1);
                checkOutput($sformatf("sweep_sum_%0d_%0d", d, b), 32'(sumOut), 32'(total[3:0]));
                checkOutput($sformatf("sweep_carry_%0d_%0d", d, b), 32'(carryOut), 32'(total[4]));
                checkOutput($sformatf("sweep_mismatch_%0d_%0d", d, b), 32'(mismatch), 32'd0);
            end
        end
        start = 1'b0;
        applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_restore_adder.md
# serial_restore_adder

Bit-serial, LSB-first adder that takes the outputs of the subtractor datapath and rebuilds the minuend. It computes a = d + b mod 2^W from a difference word d and subtrahend b. It can also check that the carry-out matches the subtractor's borrow. It sits after the half-subtractor chain as the add-back/verification stage and trades W cycles per operation for a single one-bit adder cell.

## Interface
Parameters:
- W, 8, operand width in bits (W ≥ 1)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only in IDLE
- diff_in  input  W  difference word d, captured on accepted start
- sub_in  input  W  subtrahend b, captured on accepted start
- borrow_in  input  1  borrow from the subtractor, captured on accepted start
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse, result valid
- sum_out  output  W  reconstructed minuend; holds until the next accepted start
- carry_out  output  1  final carry of the addition
- mismatch  output  1  carry_out ≠ captured borrow_in; valid with done, held like sum_out

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE → SHIFT on start=1.
  - Latch diff_in, sub_in and borrow_in into shift registers.
  - Clear the carry flip-flop and the bit counter.
  - Clear sum_out, carry_out and mismatch.
- SHIFT:
  - Each cycle, add the LSB of each operand register plus the carry.
  - Shift the sum bit into the result register from the MSB end, so bit i lands at position i after W shifts.
  - Shift both operand registers right by 1, update the carry, and increment the counter.
  - After the W-th bit (counter = W-1), go to DONE.
- DONE:
  - Assert done for exactly one cycle.
  - Drive carry_out with the final carry and update mismatch.
  - Go to IDLE.
- start is ignored in SHIFT and DONE; no queuing.
- Arithmetic:
  - sum_out = (d + b) mod 2^W.
  - carry_out = bit W of d + b.
  - For a correct subtractor, carry_out equals borrow.
- Counter width: $clog2(W)+1 bits; no wrap occurs within one operation.
- W=1: SHIFT lasts exactly one cycle.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum_out=0, carry_out=0, mismatch=0, carry and counter cleared.
- Latency: start sampled high at edge 0 gives busy=1 from edge 0 and done=1 in the cycle after edge W+1. The result is registered.
- Throughput: one operation every W+2 cycles. A start held high continuously is accepted again at the first IDLE cycle after DONE.
- rst asserted at any point, including mid-SHIFT or during DONE, aborts the operation. On the next edge all outputs take their reset values and done is not pulsed. rst has priority over start.

## Configuration
- SERIAL_RESTORE_ADDER_CHECK_EN defined:
  - borrow_in is captured.
  - mismatch is computed and registered in DONE.
- Not defined:
  - borrow_in is unused and no capture register is built.
  - mismatch is tied to 0.
  - All other behaviour is identical.

## Structure
- Package serial_restore_adder_pkg holds:
  - the state encoding typedef (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the default width constant.
- Sub-module full_adder_bit: combinational one-bit full adder (a, b, cin → s, cout), instantiated once for the serial datapath.
- Top module contains the FSM, counter, operand/result shift registers, carry flip-flop and check logic.

## Test plan
All scenarios use W=4.
- Basic add: diff_in=4'b0011, sub_in=4'b0101, borrow_in=0, start pulse.
  - Required: sum_out=4'b1000, carry_out=0, mismatch=0.
  - done exactly 5 cycles after the start edge; busy high for 5 cycles.
- Negative result (a=2, b=5): diff_in=4'b1101, sub_in=4'b0101, borrow_in=1.
  - Required: sum_out=4'b0010, carry_out=1, mismatch=0.
- Check path: same operands as the negative-result case with borrow_in=0.
  - With the macro: mismatch=1.
  - Without the macro: mismatch=0.
- Start while busy: second start with diff_in=4'hF asserted at cycle 2 of SHIFT.
  - Required: ignored; first result unchanged; only one done pulse.
- Reset mid-operation: rst high for one cycle during cycle 2 of SHIFT.
  - Required: busy=0, sum_out=0, carry_out=0 next cycle; no done.
  - A following start with 4'h1+4'h1 gives sum_out=4'h2.
- Exhaustive back-to-back: start held high across all 256 (d, b) pairs.
  - Required: each sum_out=(d+b)&4'hF and each carry_out=(d+b)>>4.
  - One done every 6 cycles.
